// File: rtl/dbuf_scanout_reader.sv
// Read-side scanout engine for the two-RAM frame double buffer: raster-scans the
// selected read RAM, streams pixels over valid/ready and hands the buffer back via map.
module dbuf_scanout_reader #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int X_W    = 8,
  parameter int Y_W    = 8,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram1_read_en,
  input  logic              ram2_read_en,
  input  logic [DATA_W-1:0] ram1_q,
  input  logic [DATA_W-1:0] ram2_q,
  input  logic              write_done,
  output logic              rd_en,
  output logic [X_W-1:0]    rd_x,
  output logic [Y_W-1:0]    rd_y,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              map,
  output logic              sel_err
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, SWAP_WAIT, SWAP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eol;
  } pix_t;

  state_t          state, state_nxt;
  logic            sel, wd_seen;
  logic [X_W-1:0]  cx, ix;
  logic [Y_W-1:0]  cy, iy;
  logic            rd_sof, rd_eol;
  logic            ret_vld, ret_sof, ret_eol;
  pix_t            obuf [3];
  pix_t            ret_pix;
  logic [1:0]      occ, wr_idx;
  logic [2:0]      credit;
  logic            start, both, pop, push, issue, last_addr;

  assign start     = (state == IDLE) && (ram1_read_en ^ ram2_read_en);
  assign both      = (state == IDLE) && ram1_read_en && ram2_read_en;
  assign pix_valid = (occ != 2'd0);
  assign pop       = pix_valid && pix_ready;
  assign push      = ret_vld;
  assign wr_idx    = occ - {1'b0, pop};

  // Entries buffered after this edge plus reads still in the RAM pipe; a new
  // read is only allowed if it can never overflow the 3-entry output buffer.
  assign credit    = {1'b0, occ} + {2'b0, ret_vld} + {2'b0, rd_en} - {2'b0, pop};

  // The frame's first read is issued straight out of IDLE at (0,0).
  assign ix        = (state == IDLE) ? '0 : cx;
  assign iy        = (state == IDLE) ? '0 : cy;
  assign issue     = (start || state == READ) && (credit < 3'd3);
  assign last_addr = (ix == X_W'(WIDTH-1)) && (iy == Y_W'(HEIGHT-1));

  assign ret_pix.data = sel ? ram2_q : ram1_q;
  assign ret_pix.sof  = ret_sof;
  assign ret_pix.eol  = ret_eol;

  assign pix_data = obuf[0].data;
  assign pix_sof  = pix_valid && obuf[0].sof;
  assign pix_eol  = pix_valid && obuf[0].eol;
  assign map      = (state == SWAP);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = (issue && last_addr) ? DRAIN : READ;
      READ:      if (issue && last_addr) state_nxt = DRAIN;
      // Leave once the final pixel is being accepted and nothing is in flight.
      DRAIN:     if (!rd_en && !ret_vld && (occ == {1'b0, pop})) state_nxt = SWAP_WAIT;
      SWAP_WAIT: if (wd_seen) state_nxt = SWAP;
      SWAP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel     <= 1'b0;
      sel_err <= 1'b0;
      wd_seen <= 1'b0;
      rd_en   <= 1'b0;
      rd_x    <= '0;
      rd_y    <= '0;
      cx      <= '0;
      cy      <= '0;
      rd_sof  <= 1'b0;
      rd_eol  <= 1'b0;
      ret_vld <= 1'b0;
      ret_sof <= 1'b0;
      ret_eol <= 1'b0;
      occ     <= 2'd0;
      for (int i = 0; i < 3; i++) obuf[i] <= '0;
    end else begin
      if (start) sel <= ram2_read_en;
      if (both)  sel_err <= 1'b1;
      // A write_done landing in SWAP belongs to the next frame.
      wd_seen <= write_done || (wd_seen && state != SWAP);

      rd_en <= issue;
      if (issue) begin
        rd_x   <= ix;
        rd_y   <= iy;
        rd_sof <= (ix == '0) && (iy == '0);
        rd_eol <= (ix == X_W'(WIDTH-1));
        if (ix == X_W'(WIDTH-1)) begin
          cx <= '0;
          cy <= iy + Y_W'(1);
        end else begin
          cx <= ix + X_W'(1);
          cy <= iy;
        end
      end

      ret_vld <= rd_en;
      ret_sof <= rd_sof;
      ret_eol <= rd_eol;

      // Head is the output register; a pop shifts the skid entries forward and
      // the returning pixel lands in the first free slot after the shift.
      if (pop) begin
        obuf[0] <= obuf[1];
        obuf[1] <= obuf[2];
      end
      if (push) obuf[wr_idx] <= ret_pix;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_dbuf_scanout_reader.sv
// Randomized scoreboard bench for dbuf_scanout_reader: frames of expected pixels are
// queued at frame start and a negedge monitor checks every accepted pixel and handshake rule.
module tb_dbuf_scanout_reader;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 3;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ram1_read_en = 1'b0, ram2_read_en = 1'b0;
  logic [DW-1:0] ram1_q = '0, ram2_q = '0;
  logic          write_done = 1'b0;
  logic          pix_ready = 1'b1;
  logic          rd_en, pix_valid, pix_sof, pix_eol, map, sel_err;
  logic [7:0]    rd_x, rd_y;
  logic [DW-1:0] pix_data;

  dbuf_scanout_reader #(.WIDTH(W), .HEIGHT(H), .X_W(8), .Y_W(8), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .ram1_read_en(ram1_read_en), .ram2_read_en(ram2_read_en),
    .ram1_q(ram1_q), .ram2_q(ram2_q), .write_done(write_done), .rd_en(rd_en),
    .rd_x(rd_x), .rd_y(rd_y), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .map(map), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame RAMs with one-cycle registered read.
  logic [DW-1:0] m1 [N];
  logic [DW-1:0] m2 [N];
  always @(posedge clk) if (rd_en) begin
    ram1_q <= m1[int'(rd_y) * W + int'(rd_x)];
    ram2_q <= m2[int'(rd_y) * W + int'(rd_x)];
  end

  typedef struct {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  bit rnd_ready = 0;
  initial forever begin
    @(posedge clk); #1;
    pix_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
  end

  // Monitor: scoreboard pops, stall stability, occupancy bound, map pulse shape.
  int acc_cnt = 0, rd_total = 0, map_cnt = 0, map_cyc = -1, last_acc_cyc = -1, outst = 0;
  bit prev_stall = 0, prev_map = 0;
  logic [DW+1:0] prev_pix;
  always @(negedge clk) begin
    if (reset) begin
      outst = 0; prev_stall = 0; prev_map = 0;
    end else begin
      if (prev_stall) chk("stall_hold", {pix_valid, pix_sof, pix_eol, pix_data}, {1'b1, prev_pix});
      if (rd_en) begin
        rd_total++; outst++;
        chk("outstanding_le3", 32'(outst <= 3), 1);
      end
      if (map) begin
        map_cnt++; map_cyc = cyc;
        chk("map_single_cycle", 32'(prev_map), 0);
      end
      prev_map = map;
      if (pix_valid && pix_ready) begin
        outst--; acc_cnt++;
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_pixel: got data %0h, expected no pixel", pix_data);
        end else begin
          e = sb.pop_front();
          chk("pix_data", pix_data, e.d);
          chk("pix_sof", pix_sof, e.sof);
          chk("pix_eol", pix_eol, e.eol);
          if (sb.size() == 0) last_acc_cyc = cyc;
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = {pix_sof, pix_eol, pix_data};
    end
  end

  task automatic load_rams();
    for (int i = 0; i < N; i++) begin
      m1[i] = DW'($urandom);
      m2[i] = m1[i] ^ DW'(1 + $urandom % 7);
    end
  endtask

  // Reference: the whole frame in raster order from the chosen RAM.
  task automatic push_frame(input bit s);
    for (int i = 0; i < N; i++)
      sb.push_back('{d: (s ? m2[i] : m1[i]), sof: (i == 0), eol: ((i % W) == W - 1)});
  endtask

  task automatic pulse_wd();
    @(posedge clk); #1 write_done = 1'b1;
    @(posedge clk); #1 write_done = 1'b0;
  endtask

  task automatic start_frame(input bit s, output int k0);
    load_rams();
    push_frame(s);
    @(posedge clk); #1;
    if (s) ram2_read_en = 1'b1; else ram1_read_en = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    k0 = cyc;
    chk("first_rd_en", rd_en, 1);
    chk("first_rd_xy", {rd_x, rd_y}, 0);
    ram1_read_en = 1'b0; ram2_read_en = 1'b0;
  endtask

  task automatic wait_map(input int base, input int limit);
    int n = 0;
    while (map_cnt == base && n < limit) begin @(negedge clk); #1; n++; end
    chk("map_seen", map_cnt, base + 1);
  endtask

  task automatic end_checks(input int base);
    repeat (5) begin @(negedge clk); #1; end
    chk("map_once_per_frame", map_cnt, base + 1);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k0, base, p, n;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_xy", {rd_x, rd_y}, 0);
    chk("rst_pix", {pix_valid, pix_sof, pix_eol, pix_data}, 0);
    chk("rst_map_selerr", {map, sel_err}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // RAM1 frame, nominal timing.
    pulse_wd(); base = map_cnt;
    start_frame(0, k0);
    wait_map(base, 200);
    chk("map_time", map_cyc, k0 + 11);
    chk("last_accept_time", last_acc_cyc, k0 + 9);
    end_checks(base);

    // RAM2 frame, ram1_q must be ignored.
    pulse_wd(); base = map_cnt;
    start_frame(1, k0);
    wait_map(base, 200);
    chk("map_time_ram2", map_cyc, k0 + 11);
    end_checks(base);

    // Random backpressure.
    for (int f = 0; f < 3; f++) begin
      rnd_ready = 1;
      pulse_wd(); base = map_cnt;
      start_frame(1'(f), k0);
      wait_map(base, 500);
      rnd_ready = 0;
      end_checks(base);
    end

    // Late write_done: waits in SWAP_WAIT.
    base = map_cnt;
    start_frame(1, k0);
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); #1; n++; end
    chk("drain_done", sb.size(), 0);
    repeat (20) begin @(negedge clk); #1; end
    chk("no_map_without_wd", map_cnt, base);
    @(posedge clk); #1 write_done = 1'b1; p = cyc;
    @(posedge clk); #1 write_done = 1'b0;
    wait_map(base, 50);
    chk("map_after_wd", map_cyc, p + 2);
    end_checks(base);

    // Both enables high: error flag, no reads; then RAM1 alone proceeds.
    pulse_wd(); base = map_cnt; p = rd_total;
    load_rams();
    @(posedge clk); #1 ram1_read_en = 1'b1; ram2_read_en = 1'b1;
    repeat (5) begin @(negedge clk); #1; end
    chk("sel_err_set", sel_err, 1);
    chk("no_rd_when_both", rd_total, p);
    push_frame(0);
    ram2_read_en = 1'b0;
    n = 0;
    while (rd_total == p && n < 20) begin @(negedge clk); #1; n++; end
    ram1_read_en = 1'b0;
    wait_map(base, 200);
    chk("sel_err_sticky", sel_err, 1);
    end_checks(base);

    // Reset after three accepted pixels.
    pulse_wd(); p = acc_cnt;
    start_frame(0, k0);
    n = 0;
    while (acc_cnt < p + 3 && n < 50) begin @(negedge clk); #1; n++; end
    reset = 1'b1; base = map_cnt;
    @(posedge clk); @(negedge clk); #1;
    chk("midrst_rd", {rd_en, rd_x, rd_y}, 0);
    chk("midrst_pix", {pix_valid, pix_sof, pix_eol, pix_data}, 0);
    chk("midrst_map_selerr", {map, sel_err}, 0);
    sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) begin @(negedge clk); #1; end
    chk("no_map_after_reset", map_cnt, base);
    pulse_wd();
    start_frame(1, k0);
    wait_map(base, 200);
    chk("map_time_after_reset", map_cyc, k0 + 11);
    end_checks(base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dbuf_scanout_reader.md
# dbuf_scanout_reader

Read-side engine for the two-RAM frame double buffer. Each frame, it takes the read enables from the buffer controller and selects the RAM currently assigned for reading. It then scans that RAM in raster order and streams pixels downstream over a valid/ready interface. When both the frame read and the writer's fill are finished, it issues the one-cycle `map` swap pulse back to the controller.

## Interface
- `WIDTH`, default 160: pixels per line.
- `HEIGHT`, default 120: lines per frame.
- `X_W`, default 8: width of the x address.
- `Y_W`, default 8: width of the y address.
- `DATA_W`, default 3: width of a pixel word.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `ram1_read_en`  in  1  RAM1 is the read buffer.
- `ram2_read_en`  in  1  RAM2 is the read buffer.
- `ram1_q`  in  DATA_W  RAM1 read data, valid 1 cycle after the address.
- `ram2_q`  in  DATA_W  RAM2 read data, valid 1 cycle after the address.
- `write_done`  in  1  one-cycle pulse: the writer has finished filling its buffer.
- `rd_en`  out  1  read strobe for the selected RAM.
- `rd_x`  out  X_W  read column.
- `rd_y`  out  Y_W  read row.
- `pix_valid`  out  1  `pix_data` is valid.
- `pix_ready`  in  1  downstream accepts the pixel.
- `pix_data`  out  DATA_W  pixel word.
- `pix_sof`  out  1  marks pixel (0,0).
- `pix_eol`  out  1  marks x = WIDTH-1.
- `map`  out  1  one-cycle buffer-swap pulse to the controller.
- `sel_err`  out  1  sticky flag: both read enables were seen high in IDLE.

## Operation
- States: IDLE, READ, DRAIN, SWAP_WAIT, SWAP.
- IDLE
  - Exactly one read enable high: latch `sel` (0 = RAM1, 1 = RAM2), clear x and y, go to READ.
  - Both high: set `sel_err` and stay in IDLE.
  - Neither high: stay in IDLE.
- `sel` is held for the whole frame; read-enable changes outside IDLE are ignored.
- READ
  - Issue `rd_en`, `rd_x`, `rd_y` when `occupancy + in_flight < 3`.
  - Output buffer is 3 entries: the output register plus a 2-deep skid.
  - Addresses advance x-fastest; x wraps at WIDTH-1 to 0 and y increments.
  - After (WIDTH-1, HEIGHT-1) is issued, go to DRAIN.
- Returned data is taken from `sel ? ram2_q : ram1_q` one cycle after its `rd_en`, tagged with sof/eol, and pushed into the buffer.
- DRAIN: go to SWAP_WAIT when `in_flight == 0` and the buffer is empty (last pixel accepted).
- SWAP_WAIT: go to SWAP when `wd_seen` is set.
- `wd_seen` is set by a `write_done` pulse in any state, including the cycle of entry, and is cleared in SWAP.
- SWAP: assert `map` for exactly one cycle, clear `wd_seen`, return to IDLE.
  - The controller's read enables update on that edge and are sampled in IDLE on the next cycle.
- `write_done` arriving in SWAP is kept: it sets `wd_seen` for the next frame.
- `pix_data`, `pix_sof`, `pix_eol` hold stable while `pix_valid && !pix_ready`.
- The buffer never overflows, and data is never dropped or duplicated.

## Timing
- Reset values: state IDLE; `rd_en` 0; `rd_x`, `rd_y` 0; `pix_valid` 0; `pix_data` 0; `pix_sof`, `pix_eol` 0; `map` 0; `sel_err` 0; `wd_seen` 0; buffer empty; `in_flight` 0.
- Reset mid-frame: all in-flight and buffered pixels are discarded, and no `map` is produced.
- `rd_en`, `rd_x`, `rd_y` are registered outputs.
- Latency: `rd_en` in cycle c, RAM data in cycle c+1, `pix_valid` in cycle c+2.
- Throughput: 1 pixel/cycle sustained while `pix_ready` is held high.
- Frame timing with `pix_ready` = 1 and `write_done` already seen:
  - IDLE detect at cycle t; first `rd_en` at t+1; last `rd_en` at t+WIDTH·HEIGHT.
  - Last pixel accepted at t+WIDTH·HEIGHT+2; `map` at t+WIDTH·HEIGHT+4.
- `map` is never high for two consecutive cycles and occurs at most once per frame.

## Test plan
- WIDTH=4, HEIGHT=2; `ram1_read_en`=1; `write_done` pulsed before the frame; ready=1.
  - Required: 8 pixels in order equal to the RAM1 model.
  - Required: `pix_sof` on pixel 0 only; `pix_eol` on pixels 3 and 7; one `map` pulse at t+12.
- Same frame, RAM2 selected.
  - Required: data comes from `ram2_q` only; `ram1_q` is ignored.
- Random `pix_ready` (50%).
  - Required: no loss, duplicates or reordering; outputs stable while stalled; `rd_en` never issued with `occupancy + in_flight ≥ 3`.
- `write_done` pulsed 20 cycles after DRAIN ends.
  - Required: FSM waits in SWAP_WAIT; `map` 2 cycles after the pulse.
- Both read enables = 1 in IDLE.
  - Required: `sel_err`=1; no `rd_en`.
  - Then RAM1 only: frame proceeds and `sel_err` stays 1.
- `reset` asserted after 3 pixels accepted.
  - Required: next cycle all outputs are at reset values; no `map`.
  - Required: the next frame restarts at (0,0) with `pix_sof`.
